// File: rtl/alu_pkg.sv
// ALU control encodings and legality check.
// Shared by the issue arbiter and the ALU control decoder.
package alu_pkg;

    localparam int ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'b1100;

    function automatic logic alu_op_legal(
        input logic [ALU_CTRL_W-1:0] op
    );
        logic ok;
        case (op)
            ALU_AND,
            ALU_OR,
            ALU_ADD,
            ALU_SUB,
            ALU_SLT,
            ALU_NOR: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid request at or after ptr.
// The pointer register lives in the caller.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    always_comb begin
        int   j;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (en && !found && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = IDW'(j);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one combinational ALU between NREQ requesters through a
// round-robin grant and a single-entry response register.
module alu_issue_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*W-1:0]          req_a,
    input  logic [NREQ*W-1:0]          req_b,
    input  logic [NREQ*ALU_CTRL_W-1:0] req_op,
    output logic [W-1:0]               alu_a,
    output logic [W-1:0]               alu_b,
    output logic [ALU_CTRL_W-1:0]      alu_ctrl,
    input  logic [W-1:0]               alu_result,
    input  logic                       alu_zero,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDW-1:0]             rsp_id,
    output logic [W-1:0]               rsp_result,
    output logic                       rsp_zero,
    output logic                       rsp_err
);

    localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

    logic [IDW-1:0]        ptr;
    logic                  free;
    logic                  arb_en;
    logic [NREQ-1:0]       gnt;
    logic [IDW-1:0]        gnt_idx;
    logic                  accept;
    logic [W-1:0]          sel_a;
    logic [W-1:0]          sel_b;
    logic [ALU_CTRL_W-1:0] sel_op;
    logic                  op_ok;

    // Reset also gates the grant so nothing is handshaken while held.
    assign free   = !rsp_valid || rsp_ready;
    assign arb_en = free && rst_n;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = ALU_ADD;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a  = req_a[i*W +: W];
                sel_b  = req_b[i*W +: W];
                sel_op = req_op[i*ALU_CTRL_W +: ALU_CTRL_W];
            end
        end
    end

    assign op_ok = alu_op_legal(sel_op);

    // Idle and illegal codes both fall back to ADD.
    assign alu_a    = sel_a;
    assign alu_b    = sel_b;
    assign alu_ctrl = op_ok ? sel_op : ALU_ADD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (accept) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= gnt_idx;
            rsp_zero   <= alu_zero;
            rsp_result <= op_ok ? alu_result : '0;
            rsp_err    <= !op_ok;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a behavioural ALU
// closing the loop from alu_a/alu_b/alu_ctrl back to alu_result/alu_zero.
module tb_alu_issue_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 32;
    localparam int IDW  = 1;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*4-1:0] req_op;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [3:0]        alu_ctrl;
    logic [W-1:0]      alu_result;
    logic              alu_zero;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_result;
    logic              rsp_zero;
    logic              rsp_err;

    int checks = 0;
    int passes = 0;

    alu_issue_arbiter #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b1100: alu_result = ~(alu_a | alu_b);
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_a == alu_b);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
        req_a[31:0] = a;
        req_b[31:0] = b;
        req_op[3:0] = op;
    endtask

    task automatic set1(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op);
        req_a[63:32] = a;
        req_b[63:32] = b;
        req_op[7:4]  = op;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_id", 32'(rsp_id), 32'h0);
        chk("rst_result", rsp_result, 32'h0);
        chk("rst_zero_err", {30'd0, rsp_zero, rsp_err}, 32'h0);
        chk("rst_ctrl", 32'(alu_ctrl), 32'h2);
        req_valid = 2'b00;
        #2;
        rst_n = 1'b1;

        // single request
        tick();
        set0(32'd50, 32'd20, 4'b0010);
        req_valid = 2'b01;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_alu_a", alu_a, 32'd50);
        tick();
        req_valid = 2'b00;
        chk("t1_rvalid", 32'(rsp_valid), 32'h1);
        chk("t1_id", 32'(rsp_id), 32'h0);
        chk("t1_result", rsp_result, 32'd70);
        chk("t1_zero_err", {30'd0, rsp_zero, rsp_err}, 32'h0);
        tick();
        chk("t1_drain", 32'(rsp_valid), 32'h0);
        chk("t1_hold", rsp_result, 32'd70);

        // ptr is 1 now: lone req1 request moves it back to 0
        set1(32'd1, 32'd1, 4'b0010);
        req_valid = 2'b10;
        #1;
        chk("p_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        chk("p_result", rsp_result, 32'd2);

        // contention
        set0(32'd50, 32'd55, 4'b0110);
        set1(32'hFFFF_FFFD, 32'd2, 4'b0111);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk("t2_id", 32'(rsp_id), 32'(k % 2));
            chk("t2_result", rsp_result,
                (k % 2 == 0) ? 32'hFFFF_FFFB : 32'h1);
            chk("t2_valid", 32'(rsp_valid), 32'h1);
        end
        req_valid = 2'b00;

        // backpressure
        set0(32'd7, 32'd7, 4'b0000);
        set1(32'd10, 32'd3, 4'b0010);
        req_valid = 2'b01;
        tick();
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_ready", 32'(req_ready), 32'h0);
            chk("t3_result", rsp_result, 32'd7);
            chk("t3_vz", {30'd0, rsp_valid, rsp_zero}, 32'h3);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t3_accept", 32'(req_ready), 32'h2);
        chk("t3_still", 32'(rsp_valid), 32'h1);
        tick();
        req_valid = 2'b00;
        chk("t3_valid2", 32'(rsp_valid), 32'h1);
        chk("t3_id2", 32'(rsp_id), 32'h1);
        chk("t3_result2", rsp_result, 32'd13);
        chk("t3_zero2", 32'(rsp_zero), 32'h0);

        // illegal op
        set1(32'd5, 32'd5, 4'b0011);
        req_valid = 2'b10;
        #1;
        chk("t4_ctrl", 32'(alu_ctrl), 32'h2);
        chk("t4_alu_b", alu_b, 32'd5);
        tick();
        req_valid = 2'b00;
        chk("t4_err", 32'(rsp_err), 32'h1);
        chk("t4_result", rsp_result, 32'h0);
        chk("t4_zero", 32'(rsp_zero), 32'h1);
        chk("t4_id", 32'(rsp_id), 32'h1);

        // NOR then OR; the first grant also shows ptr wrapped to 0
        set0(32'h0F0F_0000, 32'h0000_00FF, 4'b1100);
        set1(32'h0F0F_0000, 32'h0000_00FF, 4'b0001);
        req_valid = 2'b11;
        #1;
        chk("t5_ptr", 32'(req_ready), 32'h1);
        tick();
        chk("t5_nor", rsp_result, 32'hF0F0_FF00);
        chk("t5_err", 32'(rsp_err), 32'h0);
        tick();
        req_valid = 2'b00;
        chk("t5_or", rsp_result, 32'h0F0F_00FF);
        chk("t5_id", 32'(rsp_id), 32'h1);

        // reset mid-operation with ptr=1
        set0(32'd1, 32'd2, 4'b0010);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        #1;
        chk("t6_pre", 32'(req_ready), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async", 32'(rsp_valid), 32'h0);
        chk("t6_noready", 32'(req_ready), 32'h0);
        tick();
        chk("t6_gone", 32'(rsp_valid), 32'h0);
        req_valid = 2'b11;
        #2;
        rst_n = 1'b1;
        #1;
        chk("t6_first", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        chk("t6_id", 32'(rsp_id), 32'h0);
        chk("t6_result", rsp_result, 32'd3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
